// File: rtl/vga_rect_writer.sv
// Rectangle-fill write engine: turns fill commands into a word-per-grant stream of
// framebuffer writes. Optional frame clipping is enabled by defining VGA_RECT_WRITER_CLIP_EN.
module vga_rect_writer #(
  parameter logic [14:0] BASE_ADDR = 15'h0000,
  parameter int          ROW_WORDS = 80,
  parameter int          ROWS      = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  input  logic        mem_grant,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state | meaning
  // IDLE  | ready for a command; rejects raise err for one cycle
  // FILL  | presenting writes, advancing one word per grant
  // DONE  | done pulse, last busy cycle

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [8:0]  ROW_WORDS_9 = 9'(ROW_WORDS);
  localparam logic [8:0]  ROWS_9      = 9'(ROWS);
  localparam logic [14:0] ROW_STEP    = 15'(ROW_WORDS);

  state_t      state;
  logic [7:0]  col_cnt;
  logic [7:0]  row_cnt;
  logic [7:0]  w_reg;
  logic [14:0] row_base;

  logic [8:0]  x9, y9, w9, h9;
  logic [7:0]  w_eff, h_eff;
  logic        reject, empty;
  logic [14:0] y_off, start_addr;

  always_comb begin
    x9 = {2'b00, cmd_x};
    y9 = {2'b00, cmd_y};
    w9 = {1'b0, cmd_w};
    h9 = {1'b0, cmd_h};
`ifdef VGA_RECT_WRITER_CLIP_EN
    reject = (x9 >= ROW_WORDS_9) || (y9 >= ROWS_9);
    w_eff  = 8'((w9 < (ROW_WORDS_9 - x9)) ? w9 : (ROW_WORDS_9 - x9));
    h_eff  = 8'((h9 < (ROWS_9 - y9)) ? h9 : (ROWS_9 - y9));
`else
    reject = ((x9 + w9) > ROW_WORDS_9) || ((y9 + h9) > ROWS_9);
    w_eff  = cmd_w;
    h_eff  = cmd_h;
`endif
    empty = (w_eff == 8'd0) || (h_eff == 8'd0);
    // Constant-coefficient product, evaluated once per command at accept time.
    y_off      = 15'(cmd_y) * ROW_STEP;
    start_addr = BASE_ADDR + y_off + 15'(cmd_x);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      w_reg     <= '0;
      row_base  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          mem_we    <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              mem_data  <= {cmd_color, cmd_color};
              mem_addr  <= start_addr;
              row_base  <= start_addr;
              col_cnt   <= w_eff;
              row_cnt   <= h_eff;
              w_reg     <= w_eff;
              if (empty) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= FILL;
                mem_we <= 1'b1;
              end
            end
          end
        end
        FILL: begin
          if (mem_grant) begin
            if (col_cnt == 8'd1) begin
              if (row_cnt == 8'd1) begin
                state  <= DONE;
                mem_we <= 1'b0;
                done   <= 1'b1;
              end else begin
                // row_base tracks the address of column x0 on the current row
                row_base <= row_base + ROW_STEP;
                mem_addr <= row_base + ROW_STEP;
                col_cnt  <= w_reg;
                row_cnt  <= row_cnt - 8'd1;
              end
            end else begin
              mem_addr <= mem_addr + 15'd1;
              col_cnt  <= col_cnt - 8'd1;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_writer.sv
// Scoreboard bench for vga_rect_writer: stimulus queues expected writes/events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vga_rect_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x, cmd_y;
  logic [7:0]  cmd_w, cmd_h, cmd_color;
  logic [14:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        mem_grant;
  logic        busy, done, err;
  logic        toggle_mode;

  int vectors = 0;
  int miscompares = 0;

  localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;
  typedef struct {
    int          kind;
    logic [14:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  vga_rect_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_grant(mem_grant),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = K_WR; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_evt(input int k);
    exp_t e;
    e.kind = k; e.addr = '0; e.data = '0;
    q.push_back(e);
  endtask

  task automatic take(input int k);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d addr %0d, expected nothing", k, mem_addr);
    end else begin
      e = q.pop_front();
      check("event_kind", k, e.kind);
      if (k == K_WR) begin
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_data, e.data);
      end
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1 && mem_grant === 1'b1) take(K_WR);
    else if (mem_we === 1'b1) begin
      if (q.size() > 0 && q[0].kind == K_WR) begin
        check("stall_addr", mem_addr, q[0].addr);
        check("stall_data", mem_data, q[0].data);
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_stall: got write at %0d, expected none", mem_addr);
      end
    end
    if (done === 1'b1) take(K_DONE);
    if (err === 1'b1) take(K_ERR);
  end

  // Grant driver
  initial begin
    mem_grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) mem_grant = ~mem_grant;
      else mem_grant = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [6:0] x, input logic [6:0] y, input logic [7:0] w,
                          input logic [7:0] h, input logic [7:0] c);
    int n;
    @(negedge clk);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_evt(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done === 1'b1 || err === 1'b1) && n < lim);
    if (!(done === 1'b1 || err === 1'b1)) begin
      vectors++;
      miscompares++;
      $display("FAIL evt_timeout: got no done/err expected one within %0d", lim);
    end
  endtask

  initial begin
    int n;
    int busy_low;
    reset = 1'b1; cmd_valid = 1'b0; toggle_mode = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {cmd_ready, mem_we, busy, done, err}, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_data", mem_data, 0);
    reset = 1'b0;

    // 1: 1x1 latency
    push_wr(15'd0, 16'hA5A5); push_evt(K_DONE);
    send_cmd(7'd0, 7'd0, 8'd1, 8'd1, 8'hA5);
    @(negedge clk); check("t1_we", mem_we, 1);
    @(negedge clk); check("t1_done", done, 1); check("t1_busy", busy, 1);
    @(negedge clk); check("t1_ready", cmd_ready, 1); check("t1_done_off", done, 0);

    // 2: 3x2 at (3,2), full throughput
    push_wr(15'd163, 16'h1C1C); push_wr(15'd164, 16'h1C1C); push_wr(15'd165, 16'h1C1C);
    push_wr(15'd243, 16'h1C1C); push_wr(15'd244, 16'h1C1C); push_wr(15'd245, 16'h1C1C);
    push_evt(K_DONE);
    send_cmd(7'd3, 7'd2, 8'd3, 8'd2, 8'h1C);
    busy_low = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_low++;
    end while (done !== 1'b1 && n < 20);
    check("t2_latency", n, 7);
    check("t2_busy", busy_low, 0);

    // 3: same command with alternating grant
    push_wr(15'd163, 16'h1C1C); push_wr(15'd164, 16'h1C1C); push_wr(15'd165, 16'h1C1C);
    push_wr(15'd243, 16'h1C1C); push_wr(15'd244, 16'h1C1C); push_wr(15'd245, 16'h1C1C);
    push_evt(K_DONE);
    toggle_mode = 1'b1;
    send_cmd(7'd3, 7'd2, 8'd3, 8'd2, 8'h1C);
    wait_evt(100, n);
    check("t3_cycles", (n >= 12 && n <= 13), 1);
    toggle_mode = 1'b0;

    // 4: rectangle hanging off bottom-right corner
`ifdef VGA_RECT_WRITER_CLIP_EN
    push_wr(15'd9598, 16'h7777); push_wr(15'd9599, 16'h7777); push_evt(K_DONE);
    send_cmd(7'd78, 7'd119, 8'd5, 8'd4, 8'h77);
    wait_evt(20, n);
    check("t4_clip_cycles", n, 3);
`else
    push_evt(K_ERR);
    send_cmd(7'd78, 7'd119, 8'd5, 8'd4, 8'h77);
    @(negedge clk); check("t4_err", err, 1); check("t4_we", mem_we, 0);
    @(negedge clk); check("t4_idle", {cmd_ready, mem_we, busy}, 3'b100);
`endif

    // 5: empty command, then out-of-frame origin
    push_evt(K_DONE);
    send_cmd(7'd0, 7'd0, 8'd0, 8'd7, 8'h11);
    @(negedge clk); check("t5_empty_done", done, 1); check("t5_empty_we", mem_we, 0);
    push_evt(K_ERR);
    send_cmd(7'd80, 7'd0, 8'd1, 8'd1, 8'h22);
    @(negedge clk); check("t5_err", err, 1); check("t5_err_busy", busy, 0);

    // 6: reset during the third write of a 4x4 fill
    push_wr(15'd410, 16'h5A5A); push_wr(15'd411, 16'h5A5A); push_wr(15'd412, 16'h5A5A);
    send_cmd(7'd10, 7'd5, 8'd4, 8'd4, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk); check("t6_we_off", mem_we, 0); check("t6_busy_off", busy, 0);
    @(negedge clk); check("t6_no_done", done, 0);
    #2 reset = 1'b0;
    push_wr(15'd85, 16'h3C3C); push_wr(15'd86, 16'h3C3C); push_evt(K_DONE);
    send_cmd(7'd5, 7'd1, 8'd2, 8'd1, 8'h3C);
    wait_evt(50, n);
    check("t6_after_reset", n, 3);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
